// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 key-schedule definitions.
//   NUM_ROUND_KEYS : number of round-key slots (initial key + 10 round keys)
//   ks_state_t     : key-schedule controller states
//   RCON           : round constants, entry n used for round n (entry 0 unused)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUND_KEYS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Round constant words {rc_n, 24'h0}; entry 0 is an unused zero word so
    // the table can be indexed directly by the round number.
    localparam logic [31:0] RCON [0:10] = '{
        32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
        32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
        32'h80000000, 32'h1b000000, 32'h36000000
    };

endpackage

// File: rtl/keyexpansion.sv
// -----------------------------------------------------------------------------
// keyexpansion
// Combinational single-round AES-128 key expansion: derives round key n from
// round key n-1 and rcon(n).
//   prev_key_i : previous round key, word 0 in [127:96]
//   rcon_i     : round constant word {rc_n, 24'h0}
//   next_key_o : next round key, word 0 in [127:96]
// -----------------------------------------------------------------------------
module keyexpansion
    import aes_pkg::*;
(
    input  logic [127:0] prev_key_i,
    input  logic [31:0]  rcon_i,
    output logic [127:0] next_key_o
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: the multiplicative inverse is
    // x^254 (which maps 0 to 0 as the S-box needs), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    // RotWord/SubWord/rcon on the last word, then the running XOR chain.
    always_comb begin
        w0       = prev_key_i[127:96];
        w1       = prev_key_i[95:64];
        w2       = prev_key_i[63:32];
        w3       = prev_key_i[31:0];
        rot_word = {w3[23:0], w3[31:24]};
        temp     = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])} ^ rcon_i;
        n0       = w0 ^ temp;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_schedule.sv
// -----------------------------------------------------------------------------
// key_schedule
// Sequential AES-128 key expansion into 11 round-key slots, one round per
// clock, with a combinational read port.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (clears state and all slots)
//   key_i     : cipher key, sampled with start_i
//   start_i   : single-cycle expansion request (ignored while expanding)
//   busy_o    : expansion in progress
//   ready_o   : all round keys valid
//   rd_idx_i  : round-key read index 0..10 (11..15 read as zero)
//   rd_rev_i  : reverse-order read select (only with KEYSCHED_REVERSE_READ_EN)
//   rd_key_o  : selected round key
// Build option: define KEYSCHED_REVERSE_READ_EN to add rd_rev_i, which reads
// slot[10 - rd_idx_i] for decryption ordering.
// -----------------------------------------------------------------------------
module key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_i,
    input  logic         start_i,
    output logic         busy_o,
    output logic         ready_o,
    input  logic [3:0]   rd_idx_i,
`ifdef KEYSCHED_REVERSE_READ_EN
    input  logic         rd_rev_i,
`endif
    output logic [127:0] rd_key_o
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t    state, next_state;
    logic [3:0]   cnt;
    logic [127:0] slots [NUM_ROUND_KEYS];
    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  round_rcon;
    logic [3:0]   rd_sel;

    // Round inputs; the range guards keep indexes inside the table when the
    // counter sits at 0 outside of expansion.
    always_comb begin
        prev_idx   = cnt - 4'd1;
        prev_key   = '0;
        round_rcon = '0;
        if (prev_idx <= LAST_IDX) prev_key = slots[prev_idx];
        if (cnt <= LAST_IDX) round_rcon = RCON[cnt];
    end

    keyexpansion u_round (
        .prev_key_i (prev_key),
        .rcon_i     (round_rcon),
        .next_key_o (next_key)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and status outputs; start is only honoured outside EXPAND.
    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        ready_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) next_state = EXPAND;
            end
            EXPAND: begin
                busy_o = 1'b1;
                if (cnt == LAST_IDX) next_state = DONE;
            end
            DONE: begin
                ready_o = 1'b1;
                if (start_i) next_state = EXPAND;
            end
            default: next_state = IDLE;
        endcase
    end

    // Slot storage and round counter. The counter holds at the last index so
    // it never exceeds the slot range.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
            for (int i = 0; i < NUM_ROUND_KEYS; i++) slots[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        slots[0] <= key_i;
                        cnt      <= 4'd1;
                    end
                end
                EXPAND: begin
                    slots[cnt] <= next_key;
                    if (cnt != LAST_IDX) cnt <= cnt + 4'd1;
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Combinational read port; out-of-range indexes read zero in both modes.
    always_comb begin
        rd_key_o = '0;
`ifdef KEYSCHED_REVERSE_READ_EN
        rd_sel = rd_rev_i ? (LAST_IDX - rd_idx_i) : rd_idx_i;
`else
        rd_sel = rd_idx_i;
`endif
        if (rd_idx_i <= LAST_IDX) rd_key_o = slots[rd_sel];
    end

endmodule
